// File: rtl/fir_pkg.sv
// Shared widths and a reference multiple function for the FIR tap datapath.
package fir_pkg;

    localparam int IN_DATA_WIDTH  = 17;
    localparam int OUT_DATA_WIDTH = 21;

    // Reference k*d, only for checks; the datapath itself never multiplies.
    function automatic logic [OUT_DATA_WIDTH-1:0] odd_mult_ref(
        input logic [IN_DATA_WIDTH-1:0] d,
        input logic [4:0]               k
    );
        return OUT_DATA_WIDTH'(d) * OUT_DATA_WIDTH'(k);
    endfunction

endpackage

// File: rtl/shift_add_stage.sv
// One pipeline register bank: valid follows 'valid' whenever enabled,
// data only loads when 'ld' is also set so idle cycles do not toggle it.
module shift_add_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             valid,
    output logic [WIDTH-1:0] q,
    output logic             q_vld
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q     <= '0;
            q_vld <= 1'b0;
        end else if (en) begin
            q_vld <= valid;
            if (ld) q <= d;
        end
    end

endmodule

// File: rtl/odd_multiple_gen.sv
// Two-stage shift-add pipeline producing x1,x3,...,x15 of each sample,
// with valid/ready flow control and a global stall.
module odd_multiple_gen
    import fir_pkg::*;
#(
    parameter int IN_DATA_WIDTH  = fir_pkg::IN_DATA_WIDTH,
    parameter int OUT_DATA_WIDTH = fir_pkg::OUT_DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_data_vld,
    output logic                      in_ready,
    input  logic [IN_DATA_WIDTH-1:0]  in_data,
    input  logic                      out_ready,
    output logic                      out_data_vld,
    output logic [IN_DATA_WIDTH-1:0]  out_sample,
    output logic [OUT_DATA_WIDTH-1:0] x1,
    output logic [OUT_DATA_WIDTH-1:0] x3,
    output logic [OUT_DATA_WIDTH-1:0] x5,
    output logic [OUT_DATA_WIDTH-1:0] x7,
    output logic [OUT_DATA_WIDTH-1:0] x9,
    output logic [OUT_DATA_WIDTH-1:0] x11,
    output logic [OUT_DATA_WIDTH-1:0] x13,
    output logic [OUT_DATA_WIDTH-1:0] x15
);

    localparam int OW  = OUT_DATA_WIDTH;
    localparam int S1W = IN_DATA_WIDTH + 6 * OW;
    localparam int S2W = IN_DATA_WIDTH + 8 * OW;

    generate
        if (OUT_DATA_WIDTH != IN_DATA_WIDTH + 4) begin : g_width_chk
            $error("OUT_DATA_WIDTH must equal IN_DATA_WIDTH+4");
        end
    endgenerate

    logic stall, accept;

    assign stall    = out_data_vld & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_data_vld & in_ready;

    // Stage 1: everything reachable with one shift and one add/sub.
    logic [OW-1:0] d;
    logic [OW-1:0] n_x1, n_x3, n_x5, n_x7, n_x9, n_x15;

    assign d     = OW'(in_data);
    assign n_x1  = d;
    assign n_x3  = (d << 1) + d;
    assign n_x5  = (d << 2) + d;
    assign n_x7  = (d << 3) - d;
    assign n_x9  = (d << 3) + d;
    assign n_x15 = (d << 4) - d;

    logic [S1W-1:0] s1_d, s1_q;
    logic           s1_vld;
    logic [IN_DATA_WIDTH-1:0] s1_sample;
    logic [OW-1:0] s1_x1, s1_x3, s1_x5, s1_x7, s1_x9, s1_x15;

    assign s1_d = {in_data, n_x1, n_x3, n_x5, n_x7, n_x9, n_x15};
    assign {s1_sample, s1_x1, s1_x3, s1_x5, s1_x7, s1_x9, s1_x15} = s1_q;

    shift_add_stage #(.WIDTH(S1W)) u_stage1 (
        .clk   (clk),
        .reset (reset),
        .en    (~stall),
        .ld    (accept),
        .d     (s1_d),
        .valid (accept),
        .q     (s1_q),
        .q_vld (s1_vld)
    );

    // Stage 2: x11 and x13 are built from the registered x9 and x1.
    logic [OW-1:0]  n_x11, n_x13;
    logic [S2W-1:0] s2_d, s2_q;

    assign n_x11 = s1_x9 + (s1_x1 << 1);
    assign n_x13 = s1_x9 + (s1_x1 << 2);
    assign s2_d  = {s1_sample, s1_x1, s1_x3, s1_x5, s1_x7, s1_x9, n_x11, n_x13, s1_x15};

    shift_add_stage #(.WIDTH(S2W)) u_stage2 (
        .clk   (clk),
        .reset (reset),
        .en    (~stall),
        .ld    (s1_vld),
        .d     (s2_d),
        .valid (s1_vld),
        .q     (s2_q),
        .q_vld (out_data_vld)
    );

    assign {out_sample, x1, x3, x5, x7, x9, x11, x13, x15} = s2_q;

    // Sanity check of the widest shift-add results against the reference.
    always @(posedge clk) begin
        if (!reset && out_data_vld) begin
            assert (x15 == odd_mult_ref(out_sample, 5'd15) &&
                    x13 == odd_mult_ref(out_sample, 5'd13) &&
                    x11 == odd_mult_ref(out_sample, 5'd11));
        end
    end

endmodule
